// File: rtl/lineclear.sv
`default_nettype none
// ============================================================================
//  Module   : lineclear
//  Purpose  : Line-clear and scoring stage. Takes a locked playfield, removes
//             every completely filled row (one row examined per clock),
//             compacts the rows above downward, returns the compacted field
//             and accumulates a saturating score.
//  Ports    :
//    clk           in   system clock, rising-edge active
//    rst           in   asynchronous active-high reset
//    start         in   piece-locked pulse, accepted only while idle
//    new_game      in   synchronous clear of score and results
//    grid_in       in   [ROWS][COLS] playfield, captured on start accept
//    grid_out      out  [ROWS][COLS] compacted playfield from last pass
//    lines_cleared out  rows removed in last pass (saturates at 7)
//    score         out  accumulated score (saturates at all-ones)
//    busy          out  pass in progress
//    done          out  one-cycle pulse when results are updated
//  Revision : 1.0  initial release
// ============================================================================
module lineclear #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int SCORE_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           new_game,
  input  logic [ROWS-1:0][COLS-1:0]      grid_in,
  output logic [ROWS-1:0][COLS-1:0]      grid_out,
  output logic [2:0]                     lines_cleared,
  output logic [SCORE_W-1:0]             score,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W = $clog2(ROWS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ROW_W-1:0]     LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [SCORE_W+3:0]   SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic [ROWS-1:0][COLS-1:0]   work;
  logic [ROWS-1:0][COLS-1:0]   work_shifted;
  logic [ROW_W-1:0]            r;
  logic [2:0]                  cnt;
  logic                        row_full;
  logic                        enter_done;
  logic [SCORE_W+3:0]          score_sum;

  // Points awarded for a pass that removed n rows.
  function automatic logic [3:0] pts(input logic [2:0] n);
    case (n)
      3'd0:    pts = 4'd0;
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      default: pts = 4'd8;
    endcase
  endfunction

  assign row_full   = &work[r];
  assign enter_done = (state == ST_SCAN) && !row_full && (r == '0);

  // Score is summed with four guard bits so an overflow is visible and can
  // be clamped instead of wrapping.
  assign score_sum  = {4'b0000, score} + {{SCORE_W{1'b0}}, pts(cnt)};

  // Remove row r: every row at or above it drops by one and an empty row
  // enters at the top. Rows below r keep their contents.
  always_comb begin
    work_shifted = work;
    for (int k = ROWS - 1; k >= 1; k--) begin
      if (k <= int'(r)) begin
        work_shifted[k] = work[k-1];
      end
    end
    work_shifted[0] = '0;
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)      state_nxt = ST_SCAN;
      ST_SCAN: if (enter_done) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
    if (new_game) begin
      state_nxt = ST_IDLE;
    end
  end

  // ------------------------------------------------------------ state outputs
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work          <= '0;
      r             <= '0;
      cnt           <= '0;
      grid_out      <= '0;
      lines_cleared <= '0;
      score         <= '0;
    end else if (new_game) begin
      work          <= '0;
      r             <= '0;
      cnt           <= '0;
      grid_out      <= '0;
      lines_cleared <= '0;
      score         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work <= grid_in;
            r    <= LAST_ROW;
            cnt  <= '0;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            // r stays put: the row just shifted into position r is re-checked.
            work <= work_shifted;
            cnt  <= (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
          end else if (r != '0) begin
            r <= r - ROW_W'(1);
          end else begin
            grid_out      <= work;
            lines_cleared <= cnt;
            score         <= (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                     : score_sum[SCORE_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lineclear.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lineclear
//  Purpose  : Directed self-checking bench for lineclear. Drives playfields
//             with hand-computed expected results and checks latency, the
//             compacted field, line count, score saturation, start-while-busy,
//             new_game abort and asynchronous reset abort.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_lineclear;

  localparam int ROWS    = 22;
  localparam int COLS    = 10;
  localparam int SCORE_W = 8;

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 new_game;
  grid_t                grid_in;
  grid_t                grid_out;
  logic [2:0]           lines_cleared;
  logic [SCORE_W-1:0]   score;
  logic                 busy;
  logic                 done;

  int tests_run = 0;
  int tests_failed = 0;

  lineclear #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .new_game      (new_game),
    .grid_in       (grid_in),
    .grid_out      (grid_out),
    .lines_cleared (lines_cleared),
    .score         (score),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a pass at a negedge, count edges after accept until done is seen.
  task automatic run_pass(input string tag, input grid_t g, input int exp_lat,
                          input grid_t exp_g, input int exp_lines, input int exp_score);
    int n;
    @(negedge clk);
    grid_in = g;
    start   = 1'b1;
    @(posedge clk);          // E0
    #1;
    start   = 1'b0;
    grid_in = '0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check({tag, ".latency"}, 256'(n), 256'(exp_lat));
    check({tag, ".grid"},    256'(grid_out), 256'(exp_g));
    check({tag, ".lines"},   256'(lines_cleared), 256'(exp_lines));
    check({tag, ".score"},   256'(score), 256'(exp_score));
    @(posedge clk);
    #1;
    check({tag, ".idle"},    256'({busy, done}), 256'(0));
  endtask

  // Count any done pulse over a window of cycles.
  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check(tag, 256'(seen), 256'(0));
  endtask

  grid_t g_a, g_b, g_c, g_d, g_e, e_a, e_b, e_c, e_d;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    new_game = 1'b0;
    grid_in  = '0;

    // Row 21 full, row 20 = 1
    g_a = '0; g_a[21] = '1; g_a[20] = 10'b0000000001;
    e_a = '0; e_a[21] = 10'b0000000001;
    // Rows 18..21 full, row 17 = 0x200
    g_b = '0; g_b[21] = '1; g_b[20] = '1; g_b[19] = '1; g_b[18] = '1;
    g_b[17] = 10'b1000000000;
    e_b = '0; e_b[21] = 10'b1000000000;
    // Rows 21 and 19 full, row 20 = 0x155
    g_c = '0; g_c[21] = '1; g_c[19] = '1; g_c[20] = 10'b0101010101;
    e_c = '0; e_c[21] = 10'b0101010101;
    // Full column stack, no full row
    for (int i = 0; i < ROWS; i++) g_d[i] = 10'b0000000001;
    e_d = g_d;
    g_e = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.grid",  256'(grid_out), 256'(0));
    check("reset.lines", 256'(lines_cleared), 256'(0));
    check("reset.score", 256'(score), 256'(0));
    check("reset.busy",  256'(busy), 256'(0));
    check("reset.done",  256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    run_pass("zero",   g_e, 22, g_e, 0, 0);
    run_pass("one",    g_a, 23, e_a, 1, 1);
    run_pass("four",   g_b, 26, e_b, 4, 9);
    run_pass("split",  g_c, 24, e_c, 2, 12);
    run_pass("column", g_d, 22, e_d, 0, 12);

    // start while busy is ignored, not queued
    @(negedge clk);
    grid_in = g_e;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    grid_in = g_b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    begin
      int n;
      n = 6;
      while (n < 100) begin
        @(posedge clk);
        #1;
        n++;
        if (done) break;
      end
      check("busystart.latency", 256'(n), 256'(22));
      check("busystart.lines",   256'(lines_cleared), 256'(0));
      check("busystart.score",   256'(score), 256'(12));
    end
    watch_no_done("busystart.nosecond", 40);
    check("busystart.busy", 256'(busy), 256'(0));

    // new_game mid-scan discards the pass
    @(negedge clk);
    grid_in = g_a;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    check("newgame.busy",  256'(busy), 256'(0));
    check("newgame.score", 256'(score), 256'(0));
    check("newgame.lines", 256'(lines_cleared), 256'(0));
    check("newgame.grid",  256'(grid_out), 256'(0));
    watch_no_done("newgame.nodone", 40);

    // Preload score to 250: 31 x 8 + 2 x 1
    for (int i = 0; i < 31; i++) run_pass("pre4", g_b, 26, e_b, 4, 8 * (i + 1));
    run_pass("pre1a", g_a, 23, e_a, 1, 249);
    run_pass("pre1b", g_a, 23, e_a, 1, 250);
    run_pass("sat4",  g_b, 26, e_b, 4, 255);
    run_pass("sat1",  g_a, 23, e_a, 1, 255);

    // Asynchronous reset mid-scan
    @(negedge clk);
    grid_in = g_b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst.grid",  256'(grid_out), 256'(0));
    check("rst.lines", 256'(lines_cleared), 256'(0));
    check("rst.score", 256'(score), 256'(0));
    check("rst.busy",  256'(busy), 256'(0));
    check("rst.done",  256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("rst.nodone", 40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
